// File: rtl/seq_alu_if.sv
// Operand/opcode request and result bundle for the sequential ALU.
// Request side: start, A, B and ALU_operation. Response side: results with busy/done.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_operation;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             zero;
  logic             overflow;
  logic             div0;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, ALU_operation,
    input  res, res_hi, zero, overflow, div0, busy, done
  );

  modport slave (
    input  start, A, B, ALU_operation,
    output res, res_hi, zero, overflow, div0, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: basic ops finish in 1 cycle, MULTU/DIVU iterate for WIDTH cycles.
// Starts are accepted only while busy is low; results hold until the next accepted start.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  seq_alu_if.slave alu
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt;
  // MUL: hi=accumulator, lo=multiplier, opnd=multiplicand.
  // DIV: hi=partial remainder, lo=dividend shifting into quotient, opnd=divisor.
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q;
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             zero_q, ovf_q, div0_q, done_q;
  logic             accept;

  logic [WIDTH-1:0] add_res, sub_res, basic_res;
  logic             basic_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign accept = alu.start && (state == IDLE);

  always_comb begin
    add_res   = alu.A + alu.B;
    sub_res   = alu.A - alu.B;
    basic_res = '0;
    basic_ovf = 1'b0;
    case (alu.ALU_operation)
      4'd0: basic_res = alu.A & alu.B;
      4'd1: basic_res = alu.A | alu.B;
      4'd2: begin
        basic_res = add_res;
        basic_ovf = (alu.A[WIDTH-1] == alu.B[WIDTH-1]) && (add_res[WIDTH-1] != alu.A[WIDTH-1]);
      end
      4'd3: basic_res = alu.A ^ alu.B;
      4'd4: basic_res = ~(alu.A | alu.B);
      4'd5: basic_res = alu.A >> alu.B[SHW-1:0];
      4'd6: begin
        basic_res = sub_res;
        basic_ovf = (alu.A[WIDTH-1] != alu.B[WIDTH-1]) && (sub_res[WIDTH-1] != alu.A[WIDTH-1]);
      end
      4'd7: basic_res = {{(WIDTH-1){1'b0}}, ($signed(alu.A) < $signed(alu.B))};
      default: basic_res = '0;
    endcase
  end

  // One iteration step; the carry out of the shift-add lands in the top of the accumulator.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, opnd_q};
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    if (state == DIV) begin
      hi_nxt = div_ge ? div_diff : div_sh[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && alu.ALU_operation == OP_MULTU) state_nxt = MUL;
        else if (accept && alu.ALU_operation == OP_DIVU) state_nxt = DIV;
      end
      MUL, DIV: if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu.ALU_operation == OP_MULTU || alu.ALU_operation == OP_DIVU) begin
              opnd_q <= alu.B;
              lo_q   <= alu.A;
              hi_q   <= '0;
              cnt    <= '0;
            end else begin
              res_q    <= basic_res;
              res_hi_q <= '0;
              zero_q   <= (basic_res == '0);
              ovf_q    <= basic_ovf;
              div0_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          cnt  <= cnt + SHW'(1);
          if (cnt == LAST) begin
            res_q    <= lo_nxt;
            res_hi_q <= hi_nxt;
            zero_q   <= (lo_nxt == '0);
            ovf_q    <= (state == MUL) && (hi_nxt != '0);
            div0_q   <= (state == DIV) && (opnd_q == '0);
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu.res      = res_q;
  assign alu.res_hi   = res_hi_q;
  assign alu.zero     = zero_q;
  assign alu.overflow = ovf_q;
  assign alu.div0     = div0_q;
  assign alu.busy     = (state != IDLE);
  assign alu.done     = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: directed cases plus randomized ops against an arithmetic model.
module tb_seq_alu;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] res_hi;
    logic         zero;
    logic         ovf;
    logic         div0;
    int           cyc;
  } exp_t;

  bit   clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   busy_end = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .alu(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      s;
    logic [63:0] p;
    e.res = '0; e.res_hi = '0; e.ovf = 1'b0; e.div0 = 1'b0; e.cyc = 0;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        e.res = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: e.res = a ^ b;
      4'd4: e.res = ~(a | b);
      4'd5: e.res = a >> b[4:0];
      4'd6: begin
        e.res = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.res_hi = p[63:32];
        e.ovf = (e.res_hi != 0);
      end
      4'd9: begin
        if (b == 0) begin
          e.res = '1; e.res_hi = a; e.div0 = 1'b1;
        end else begin
          e.res = a / b; e.res_hi = a % b;
        end
      end
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.ALU_operation = op;
    @(posedge clk); #1;
    e = model(op, a, b);
    e.cyc = cyc + ((op == 4'd8 || op == 4'd9) ? W : 0);
    if (op == 4'd8 || op == 4'd9) busy_end = cyc + W;
    sb.push_back(e);
  endtask

  // Waits n edges; with hold set, start stays high with scrambled operands.
  task automatic span(input int n, input bit hold);
    for (int i = 0; i < n; i++) begin
      bus.start = hold;
      if (hold) begin
        bus.A = $urandom; bus.B = $urandom; bus.ALU_operation = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus.res, bus.res_hi, bus.zero, bus.overflow, bus.div0, bus.busy, bus.done}, '0);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", bus.busy, cyc < busy_end);
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", bus.done, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", cyc, e.cyc);
          chk("result", {bus.res, bus.res_hi, bus.zero, bus.overflow, bus.div0},
              {e.res, e.res_hi, e.zero, e.ovf, e.div0});
        end
      end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
        chk("done_missing", bus.done, 1'b1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_operation = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    rst = 1'b0;
    span(2, 1'b0);

    // Basic ops back-to-back, one start per cycle.
    for (int i = 0; i < 8; i++) issue(4'(i), 32'd31, 32'd8);
    span(2, 1'b0);

    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_res", bus.res, 32'h8000_0000);
    chk("add_ovf_flag", bus.overflow, 1'b1);
    issue(4'd6, 32'h8000_0000, 32'd1);
    chk("sub_ovf_flag", bus.overflow, 1'b1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg", bus.res, 32'd1);
    issue(4'd12, 32'h1234_5678, 32'h9);
    chk("reserved_zero", bus.zero, 1'b1);
    span(1, 1'b0);

    // Multiply with start held and operands scrambled; next op issued in the done cycle.
    issue(4'd8, 32'hFFFF_FFFF, 32'd2);
    span(W, 1'b1);
    chk("mul_res", {bus.res_hi, bus.res}, 64'h1_FFFF_FFFE);
    chk("mul_ovf", bus.overflow, 1'b1);
    issue(4'd8, 32'd0, 32'd5);
    span(W, 1'b0);
    chk("mul_zero", {bus.res, bus.zero}, {32'd0, 1'b1});

    issue(4'd9, 32'd100, 32'd7);
    span(W, 1'b0);
    chk("div_res", {bus.res, bus.res_hi, bus.div0}, {32'd14, 32'd2, 1'b0});
    issue(4'd9, 32'd100, 32'd0);
    span(W, 1'b0);
    span(3, 1'b0);
    chk("div0_hold", {bus.res, bus.res_hi, bus.div0}, {32'hFFFF_FFFF, 32'd100, 1'b1});

    // Reset ten cycles into a divide aborts it without a done pulse.
    issue(4'd9, 32'd1000, 32'd3);
    span(9, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    busy_end = 0;
    chk_all_zero("reset_mid_op");
    rst = 1'b0;
    span(W + 2, 1'b0);
    issue(4'd2, 32'd2, 32'd3);
    chk("add_after_reset", bus.res, 32'd5);
    span(1, 1'b0);

    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, rnd_opnd(), rnd_opnd());
      if (op == 4'd8 || op == 4'd9) span(W, 1'($urandom_range(0, 1)));
      else if ($urandom_range(0, 3) == 0) span(1, 1'b0);
    end

    span(W + 2, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
